// File: rtl/fcml_spi_pkg.sv
// Shared definitions for the FCML SPI duty-frame path.
// Holds the 48-bit frame layout, the decoder FSM state type and the frame
// checksum helper shared with the future TX/telemetry frame builder.
package fcml_spi_pkg;

   localparam int FRAME_W  = 48;

   localparam int SYNC_HI  = 47;
   localparam int SYNC_LO  = 44;
   localparam int DUTYA_HI = 43;
   localparam int DUTYA_LO = 32;
   localparam int DUTYB_HI = 31;
   localparam int DUTYB_LO = 20;
   localparam int DUTYC_HI = 19;
   localparam int DUTYC_LO = 8;
   localparam int CKS_HI   = 7;
   localparam int CKS_LO   = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CHECK  = 2'd1,
      ST_APPLY  = 2'd2,
      ST_REJECT = 2'd3
   } fsm_state_t;

   // XOR of the five payload bytes above the checksum byte.
   function automatic logic [7:0] frame_cks_calc(input logic [FRAME_W-1:0] frame);
      return frame[47:40] ^ frame[39:32] ^ frame[31:24] ^ frame[23:16] ^ frame[15:8];
   endfunction

endpackage

// File: rtl/frame_xor_checksum.sv
// Combinational checksum checker for a 48-bit SPI frame.
// cks_match is high when the low byte equals the XOR of the upper five bytes.
module frame_xor_checksum
   import fcml_spi_pkg::*;
(
   input  logic [FRAME_W-1:0] frame,
   output logic               cks_match
);

   // Compare the received checksum byte against the recomputed one.
   always_comb begin
      cks_match = (frame[CKS_HI:CKS_LO] == frame_cks_calc(frame));
   end

endmodule

// File: rtl/fcml_duty_frame_decoder.sv
// FCML duty frame decoder: validates 48-bit SPI frames and drives three
// clamped phase duty commands, a bad-frame counter and a link status flag.
// Optional link watchdog enabled by defining FCML_DUTY_WATCHDOG_EN; without it
// link_ok latches high on the first applied frame and duties are only forced
// to SAFE_DUTY by reset.
module fcml_duty_frame_decoder
   import fcml_spi_pkg::*;
#(
   parameter int               DUTY_W     = 12,
   parameter logic [DUTY_W-1:0] MAX_DUTY  = 12'hF00,
   parameter logic [DUTY_W-1:0] SAFE_DUTY = 12'h000,
   parameter logic [3:0]       SYNC_NIB   = 4'hA,
   parameter int               WDT_CYCLES = 1_000_000
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               spi_cs,
   input  logic [FRAME_W-1:0] spi_rdata,
   output logic [DUTY_W-1:0]  duty_a,
   output logic [DUTY_W-1:0]  duty_b,
   output logic [DUTY_W-1:0]  duty_c,
   output logic               duty_update,
   output logic               clamp_flag,
   output logic [7:0]         err_count,
   output logic               link_ok
);

   logic               cs_sync1_r;
   logic               cs_sync2_r;
   logic               cs_prev_r;
   logic               edge_s;
   logic [FRAME_W-1:0] frame_r;
   fsm_state_t         state_r;
   fsm_state_t         state_next_s;
   logic               latch_s;
   logic               apply_s;
   logic               reject_s;
   logic               cks_ok_s;
   logic               sync_ok_s;
   logic [DUTY_W-1:0]  duty_a_fld_s;
   logic [DUTY_W-1:0]  duty_b_fld_s;
   logic [DUTY_W-1:0]  duty_c_fld_s;
   logic [DUTY_W-1:0]  duty_a_clamp_s;
   logic [DUTY_W-1:0]  duty_b_clamp_s;
   logic [DUTY_W-1:0]  duty_c_clamp_s;
   logic               clamp_any_s;

   frame_xor_checksum u_cks (
      .frame     (frame_r),
      .cks_match (cks_ok_s)
   );

   // Bring the raw chip select into clk; flops idle high like the CS pin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_sync1_r <= 1'b1;
         cs_sync2_r <= 1'b1;
         cs_prev_r  <= 1'b1;
      end else begin
         cs_sync1_r <= spi_cs;
         cs_sync2_r <= cs_sync1_r;
         cs_prev_r  <= cs_sync2_r;
      end
   end

   // End-of-transaction marker: synchronized CS just went high.
   always_comb begin
      edge_s = cs_sync2_r & ~cs_prev_r;
   end

   // FSM state register and frame capture at end of transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         frame_r <= {FRAME_W{1'b0}};
      end else begin
         state_r <= state_next_s;
         if (latch_s) begin
            frame_r <= spi_rdata;
         end
      end
   end

   // Next-state logic; apply/reject strobes fire on leaving CHECK so the
   // output registers update on the second edge after the CS edge.
   always_comb begin
      state_next_s = state_r;
      latch_s      = 1'b0;
      apply_s      = 1'b0;
      reject_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (edge_s) begin
               latch_s      = 1'b1;
               state_next_s = ST_CHECK;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_CHECK: begin
            if (cks_ok_s && sync_ok_s) begin
               apply_s      = 1'b1;
               state_next_s = ST_APPLY;
            end else begin
               reject_s     = 1'b1;
               state_next_s = ST_REJECT;
            end
         end
         ST_APPLY:  state_next_s = ST_IDLE;
         ST_REJECT: state_next_s = ST_IDLE;
         default:   state_next_s = ST_IDLE;
      endcase
   end

   // Field extraction, sync check and per-phase clamping of the latched frame.
   always_comb begin
      sync_ok_s      = (frame_r[SYNC_HI:SYNC_LO] == SYNC_NIB);
      duty_a_fld_s   = frame_r[DUTYA_HI:DUTYA_LO];
      duty_b_fld_s   = frame_r[DUTYB_HI:DUTYB_LO];
      duty_c_fld_s   = frame_r[DUTYC_HI:DUTYC_LO];
      duty_a_clamp_s = (duty_a_fld_s > MAX_DUTY) ? MAX_DUTY : duty_a_fld_s;
      duty_b_clamp_s = (duty_b_fld_s > MAX_DUTY) ? MAX_DUTY : duty_b_fld_s;
      duty_c_clamp_s = (duty_c_fld_s > MAX_DUTY) ? MAX_DUTY : duty_c_fld_s;
      clamp_any_s    = (duty_a_fld_s > MAX_DUTY) | (duty_b_fld_s > MAX_DUTY) |
                       (duty_c_fld_s > MAX_DUTY);
   end

`ifdef FCML_DUTY_WATCHDOG_EN
   localparam int WDT_W = $clog2(WDT_CYCLES + 1);

   logic [WDT_W-1:0] wdt_cnt_r;
   logic [WDT_W-1:0] wdt_next_s;
   logic             wdt_expire_s;

   // Watchdog next count; a concurrent apply always beats expiry.
   always_comb begin
      if (apply_s) begin
         wdt_next_s = WDT_W'(WDT_CYCLES);
      end else if (wdt_cnt_r != {WDT_W{1'b0}}) begin
         wdt_next_s = wdt_cnt_r - {{(WDT_W-1){1'b0}}, 1'b1};
      end else begin
         wdt_next_s = wdt_cnt_r;
      end
      wdt_expire_s = (wdt_next_s == {WDT_W{1'b0}}) && !apply_s;
   end

   // Watchdog down-counter, holds at zero once expired.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdt_cnt_r <= WDT_W'(WDT_CYCLES);
      end else begin
         wdt_cnt_r <= wdt_next_s;
      end
   end
`endif

   // Registered outputs: apply new duties, force safe duty on link loss,
   // count rejected frames with saturation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_a      <= SAFE_DUTY;
         duty_b      <= SAFE_DUTY;
         duty_c      <= SAFE_DUTY;
         duty_update <= 1'b0;
         clamp_flag  <= 1'b0;
         err_count   <= 8'd0;
         link_ok     <= 1'b0;
      end else begin
         duty_update <= apply_s;
         if (apply_s) begin
            duty_a     <= duty_a_clamp_s;
            duty_b     <= duty_b_clamp_s;
            duty_c     <= duty_c_clamp_s;
            clamp_flag <= clamp_any_s;
            link_ok    <= 1'b1;
         end
`ifdef FCML_DUTY_WATCHDOG_EN
         else if (wdt_expire_s) begin
            duty_a  <= SAFE_DUTY;
            duty_b  <= SAFE_DUTY;
            duty_c  <= SAFE_DUTY;
            link_ok <= 1'b0;
         end
`endif
         if (reject_s && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_fcml_duty_frame_decoder.sv
// Directed self-checking bench for fcml_duty_frame_decoder.
// Runs with WDT_CYCLES=100; the watchdog timeout scenario is exercised when
// FCML_DUTY_WATCHDOG_EN is defined, otherwise link_ok persistence is checked.
module tb_fcml_duty_frame_decoder;

   logic        clk;
   logic        rst;
   logic        spi_cs;
   logic [47:0] spi_rdata;
   logic [11:0] duty_a;
   logic [11:0] duty_b;
   logic [11:0] duty_c;
   logic        duty_update;
   logic        clamp_flag;
   logic [7:0]  err_count;
   logic        link_ok;

   int n_checks;
   int n_fail;
   int upd_cnt;
   int first_i;

   localparam logic [47:0] FR_GOOD  = 48'hA800400100E9;
   localparam logic [47:0] FR_BADCK = 48'hA800400100E8;
   localparam logic [47:0] FR_BADSY = 48'h580040010019;
   localparam logic [47:0] FR_CLAMP = 48'hAFFF00000050;

   fcml_duty_frame_decoder #(
      .WDT_CYCLES (100)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .spi_cs      (spi_cs),
      .spi_rdata   (spi_rdata),
      .duty_a      (duty_a),
      .duty_b      (duty_b),
      .duty_c      (duty_c),
      .duty_update (duty_update),
      .clamp_flag  (clamp_flag),
      .err_count   (err_count),
      .link_ok     (link_ok)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Drive one frame with a CS low pulse, then watch 10 cycles for duty_update.
   task automatic send_frame(input logic [47:0] data, output int cnt, output int first);
      @(posedge clk);
      #1;
      spi_rdata = data;
      spi_cs    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      spi_cs = 1'b1;
      cnt    = 0;
      first  = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         if (duty_update) begin
            cnt++;
            if (first == 0) first = i;
         end
      end
   endtask

   task automatic chk_duties(input string tag, input logic [11:0] a, input logic [11:0] b,
                             input logic [11:0] c);
      chk_eq({tag, "_duty_a"}, {20'd0, duty_a}, {20'd0, a});
      chk_eq({tag, "_duty_b"}, {20'd0, duty_b}, {20'd0, b});
      chk_eq({tag, "_duty_c"}, {20'd0, duty_c}, {20'd0, c});
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      spi_cs    = 1'b1;
      spi_rdata = 48'd0;
      repeat (3) @(posedge clk);
      #1;
      chk_duties("reset", 12'h000, 12'h000, 12'h000);
      chk_eq("reset_update", {31'd0, duty_update}, 32'd0);
      chk_eq("reset_clamp", {31'd0, clamp_flag}, 32'd0);
      chk_eq("reset_err", {24'd0, err_count}, 32'd0);
      chk_eq("reset_link", {31'd0, link_ok}, 32'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // Valid frame: CS edge seen two edges after CS rises, outputs two later.
      send_frame(FR_GOOD, upd_cnt, first_i);
      chk_duties("good", 12'h800, 12'h400, 12'h100);
      chk_eq("good_upd_pulses", upd_cnt, 32'd1);
      chk_eq("good_latency", first_i, 32'd4);
      chk_eq("good_link", {31'd0, link_ok}, 32'd1);
      chk_eq("good_clamp", {31'd0, clamp_flag}, 32'd0);

      // Bad checksum.
      send_frame(FR_BADCK, upd_cnt, first_i);
      chk_eq("badck_err", {24'd0, err_count}, 32'd1);
      chk_eq("badck_upd_pulses", upd_cnt, 32'd0);
      chk_duties("badck", 12'h800, 12'h400, 12'h100);

      // Bad sync nibble, valid checksum.
      send_frame(FR_BADSY, upd_cnt, first_i);
      chk_eq("badsy_err", {24'd0, err_count}, 32'd2);
      chk_eq("badsy_upd_pulses", upd_cnt, 32'd0);
      chk_duties("badsy", 12'h800, 12'h400, 12'h100);

      // Duty A above the clamp limit.
      send_frame(FR_CLAMP, upd_cnt, first_i);
      chk_duties("clamp", 12'hF00, 12'h000, 12'h000);
      chk_eq("clamp_flag", {31'd0, clamp_flag}, 32'd1);
      chk_eq("clamp_upd_pulses", upd_cnt, 32'd1);

      // Clamp flag is rewritten by the next in-range frame.
      send_frame(FR_GOOD, upd_cnt, first_i);
      chk_eq("unclamp_flag", {31'd0, clamp_flag}, 32'd0);
      chk_duties("unclamp", 12'h800, 12'h400, 12'h100);

`ifdef FCML_DUTY_WATCHDOG_EN
      // Reload happened 6 edges before send_frame returned; 40 more is still alive.
      repeat (40) @(posedge clk);
      #1;
      chk_eq("wdt_alive_link", {31'd0, link_ok}, 32'd1);
      repeat (60) @(posedge clk);
      #1;
      chk_eq("wdt_expired_link", {31'd0, link_ok}, 32'd0);
      chk_duties("wdt_expired", 12'h000, 12'h000, 12'h000);
      send_frame(FR_GOOD, upd_cnt, first_i);
      chk_eq("wdt_recover_link", {31'd0, link_ok}, 32'd1);
      chk_duties("wdt_recover", 12'h800, 12'h400, 12'h100);
`else
      // No watchdog: link and duties persist through a long idle.
      repeat (150) @(posedge clk);
      #1;
      chk_eq("nowdt_link", {31'd0, link_ok}, 32'd1);
      chk_duties("nowdt", 12'h800, 12'h400, 12'h100);
`endif

      // Saturate the error counter: 253 more bad frames reach exactly 255.
      for (int k = 0; k < 253; k++) begin
         send_frame(FR_BADCK, upd_cnt, first_i);
      end
      chk_eq("err_at_255", {24'd0, err_count}, 32'd255);
      for (int k = 0; k < 7; k++) begin
         send_frame(FR_BADSY, upd_cnt, first_i);
      end
      chk_eq("err_saturated", {24'd0, err_count}, 32'd255);

      // Reset in the middle of a frame (CS low).
      send_frame(FR_CLAMP, upd_cnt, first_i);
      @(posedge clk);
      #1;
      spi_rdata = FR_GOOD;
      spi_cs    = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk_duties("midrst", 12'h000, 12'h000, 12'h000);
      chk_eq("midrst_update", {31'd0, duty_update}, 32'd0);
      chk_eq("midrst_clamp", {31'd0, clamp_flag}, 32'd0);
      chk_eq("midrst_err", {24'd0, err_count}, 32'd0);
      chk_eq("midrst_link", {31'd0, link_ok}, 32'd0);
      spi_cs = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst     = 1'b0;
      upd_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (duty_update) upd_cnt++;
      end
      chk_eq("midrst_discard_upd", upd_cnt, 32'd0);
      chk_duties("midrst_discard", 12'h000, 12'h000, 12'h000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fcml_duty_frame_decoder.md
Name: fcml_duty_frame_decoder

Overview:
- Sits directly downstream of the 48-bit SPI serial receiver. Consumes its parallel word `spi_rdata` at each end of transaction (`spi_cs` rising).
- Validates the frame (sync nibble plus XOR checksum) and splits it into three 12-bit phase duty commands (A/B/C) for the FCML PWM modulators.
- Clamps each duty to a maximum, counts bad frames, and runs a link watchdog that forces a safe duty when frames stop arriving.

Parameters:
- DUTY_W, 12: width of each duty command.
- MAX_DUTY, 12'hF00: upper clamp for each duty.
- SAFE_DUTY, 12'h000: duty driven after reset and on watchdog timeout.
- SYNC_NIB, 4'hA: required value of frame bits [47:44].
- WDT_CYCLES, 1_000_000: clk cycles without a valid frame before timeout. Counter width is $clog2(WDT_CYCLES+1).

Ports:
- clk  in  1  reference clock, same clock as the SPI receiver.
- rst  in  1  asynchronous, active-high reset.
- spi_cs  in  1  raw SPI chip select from the pin; asynchronous to clk.
- spi_rdata  in  48  frame word from the SPI receiver.
- duty_a  out  12  phase A duty command.
- duty_b  out  12  phase B duty command.
- duty_c  out  12  phase C duty command.
- duty_update  out  1  one-cycle strobe when new duties are applied.
- clamp_flag  out  1  set if any duty of the last applied frame was clamped.
- err_count  out  8  saturating count of rejected frames.
- link_ok  out  1  high when a valid frame has arrived within WDT_CYCLES.

Behaviour:
- Frame format:
  - [47:44] sync nibble.
  - [43:32] duty A; [31:20] duty B; [19:8] duty C.
  - [7:0] checksum = XOR of bytes [47:40], [39:32], [31:24], [23:16], [15:8].
- CS handling: `spi_cs` passes through a 2-flop synchronizer plus a prev flop. Edge E is the cycle where synced=1 and prev=0.
- FSM states: IDLE, CHECK, APPLY, REJECT.
  - IDLE: on E, latch `frame_q <= spi_rdata` and go to CHECK.
  - CHECK: evaluate sync and checksum. Both pass → APPLY; otherwise → REJECT.
  - APPLY: register clamped duties and `clamp_flag`; pulse `duty_update` for exactly 1 cycle; reload the watchdog; set `link_ok`=1; return to IDLE.
  - REJECT: `err_count` +1, saturating at 255 with no wrap; duties unchanged; return to IDLE.
- Latency: duties and `duty_update` change on the 2nd clk edge after cycle E, so they are visible in cycle E+2.
- Edges arriving while in CHECK, APPLY or REJECT are ignored; no queueing.
- Clamp: duty_x = (field > MAX_DUTY) ? MAX_DUTY : field. `clamp_flag` = OR of the three compares. It is rewritten on every APPLY.
- Watchdog:
  - Down-counter loaded to WDT_CYCLES on reset and on APPLY; decrements every cycle otherwise; holds at 0.
  - On reaching 0: `link_ok`=0 and all duties = SAFE_DUTY in the same cycle, with no `duty_update` strobe.
  - Recovery requires only the next valid APPLY.
  - APPLY coinciding with the count reaching 0: APPLY wins.
- Reset values (async, any state): duties = SAFE_DUTY, `duty_update`=0, `clamp_flag`=0, `err_count`=0, `link_ok`=0, FSM=IDLE, synchronizer flops=1 (CS idle-high). A reset in the middle of a frame discards it.

Optional Feature:
- Macro: FCML_DUTY_WATCHDOG_EN.
- Defined: watchdog behaves as described above.
- Undefined: no counter is instantiated; `link_ok` goes to 1 on the first APPLY and stays 1 until reset; duties are never forced to SAFE_DUTY except by reset.

Decomposition:
- Shared package `fcml_spi_pkg`:
  - Frame field bit positions (SYNC_HI/LO, DUTYA_HI/LO, DUTYB_HI/LO, DUTYC_HI/LO, CKS_HI/LO).
  - FRAME_W=48.
  - FSM state enum type.
- One sub-module: `frame_xor_checksum`, combinational, 48-bit in → 1-bit match out. It is reusable for the future TX/telemetry frame.

Test Plan:
- Reset, then frame 48'hA800400100E9 with a CS low→high pulse → at E+2 duty_a=0x800, duty_b=0x400, duty_c=0x100, `duty_update` pulses 1 cycle, `link_ok`=1, `clamp_flag`=0.
- Frame 48'hA800400100E8 (bad checksum) → `err_count`=1, duties unchanged, no `duty_update`.
- Frame 48'h580040010019 (bad sync nibble, valid checksum) → `err_count`+1, duties unchanged.
- Frame 48'hAFFF00000050 → duty_a=0xF00, duty_b=0x000, duty_c=0x000, `clamp_flag`=1.
- WDT_CYCLES=100, one valid frame, then 100 idle cycles → `link_ok`=0 and all duties=0x000. The next valid frame restores the values and sets `link_ok`=1.
- 260 bad frames → `err_count` saturates at 255. Assert rst mid-frame (CS low) → all outputs return to reset values immediately.
